// File: rtl/test_pattern_pkg.sv
// Shared mode encoding and seed helper for the probe pattern generator and its users.
package test_pattern_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned MAX_W  = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_MIRROR = 3'd0,
    MODE_COUNT  = 3'd1,
    MODE_WALK   = 3'd2,
    MODE_LFSR   = 3'd3,
    MODE_TOGGLE = 3'd4
  } mode_e;

  // Encodings 5-7 have no pattern of their own and behave as MIRROR.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] m);
    if (m <= 3'd4) return mode_e'(m);
    return MODE_MIRROR;
  endfunction

  function automatic logic [MAX_W-1:0] pattern_seed(input mode_e m, input int unsigned width);
    logic [MAX_W-1:0] s;
    s = '0;
    case (m)
      MODE_WALK, MODE_LFSR: s[0] = 1'b1;
      MODE_TOGGLE: begin
        for (int unsigned i = 0; i < MAX_W / 2; i++) begin
          if (i < width / 2) s[2*i] = 1'b1;
        end
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Control inputs and probe outputs of the test pattern generator.
interface test_pattern_gen_if
  import test_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV_W = 16
) ();

  logic              en;
  logic [MODE_W-1:0] mode;
  logic [DIV_W-1:0]  div;
  logic              ain;
  logic              bin;
  logic              cin;
  logic              out;
  logic [WIDTH-1:0]  allout;
  logic              tick;
  logic              wrap;

  modport master (
    output en, mode, div, ain, bin, cin,
    input  out, allout, tick, wrap
  );

  modport slave (
    input  en, mode, div, ain, bin, cin,
    output out, allout, tick, wrap
  );

endinterface

// File: rtl/pattern_prescaler.sv
// Programmable step prescaler: term marks the terminal-count cycle, tick follows it by one cycle.
module pattern_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             term,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Terminal on >= so that lowering div mid-period ends the period immediately.
  always_comb begin
    term   = en && (cnt_q >= div);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Registered probe pattern generator for logic-analyzer bring-up, with the legacy ain/bin/cin mirror.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_W     = 16,
  parameter logic [63:0] LFSR_TAPS = 64'hB400
) (
  input  logic              clk,
  input  logic              rst,
  test_pattern_gen_if.slave pif
);

  localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

  mode_e            mode_in, mode_q, mode_d;
  logic             mode_chg;
  logic             term, step, presc_rst, presc_tick;
  logic             out_comb, out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       src;
  logic [WIDTH-1:0] allout_q, allout_d;
  logic [WIDTH-1:0] mirror_val, next_step, seed_new, seed_cur;

  assign mode_in  = decode_mode(pif.mode);
  assign mode_chg = (mode_in != mode_q);
  assign out_comb = (pif.ain & pif.bin) | pif.cin;
  assign src      = {out_comb, pif.cin, pif.bin, pif.ain};
  assign seed_new = WIDTH'(pattern_seed(mode_in, WIDTH));
  assign seed_cur = WIDTH'(pattern_seed(mode_q, WIDTH));

  // A mode change clears the prescaler and swallows any coincident terminal count.
  assign presc_rst = rst | mode_chg;
  assign step      = term & ~mode_chg;

  pattern_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk (clk),
    .rst (presc_rst),
    .en  (pif.en),
    .div (pif.div),
    .term(term),
    .tick(presc_tick)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_mirror
    assign mirror_val[g] = src[(g * 4) / WIDTH];
  end

  always_comb begin
    next_step = allout_q;
    case (mode_q)
      MODE_COUNT:  next_step = allout_q + WIDTH'(1);
      MODE_WALK:   next_step = {allout_q[WIDTH-2:0], allout_q[WIDTH-1]};
      MODE_LFSR: begin
        if (allout_q == '0) next_step = seed_cur;
        else                next_step = (allout_q >> 1) ^ (allout_q[0] ? TAPS : '0);
      end
      MODE_TOGGLE: next_step = ~allout_q;
      default:     next_step = allout_q;
    endcase
  end

  always_comb begin
    mode_d   = mode_in;
    out_d    = out_comb;
    allout_d = allout_q;
    wrap_d   = 1'b0;
    if (mode_in == MODE_MIRROR) begin
      allout_d = mirror_val;
    end else if (mode_chg) begin
      allout_d = seed_new;
    end else if (step) begin
      allout_d = next_step;
      wrap_d   = (next_step == seed_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_MIRROR;
      allout_q <= '0;
      wrap_q   <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      allout_q <= allout_d;
      wrap_q   <= wrap_d;
      out_q    <= out_d;
    end
  end

  assign pif.allout = allout_q;
  assign pif.tick   = presc_tick;
  assign pif.wrap   = wrap_q;
  assign pif.out    = out_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen at WIDTH 16, 15 and 4.
module tb_test_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  test_pattern_gen_if #(.WIDTH(16), .DIV_W(16)) if16 ();
  test_pattern_gen_if #(.WIDTH(15), .DIV_W(16)) if15 ();
  test_pattern_gen_if #(.WIDTH(4),  .DIV_W(16)) if4 ();

  test_pattern_gen #(.WIDTH(16), .DIV_W(16), .LFSR_TAPS(64'hB400)) u_dut16 (
    .clk(clk), .rst(rst), .pif(if16)
  );
  test_pattern_gen #(.WIDTH(15), .DIV_W(16), .LFSR_TAPS(64'h6000)) u_dut15 (
    .clk(clk), .rst(rst), .pif(if15)
  );
  test_pattern_gen #(.WIDTH(4), .DIV_W(16), .LFSR_TAPS(64'hC)) u_dut4 (
    .clk(clk), .rst(rst), .pif(if4)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          seen [0:65535];
  logic [15:0] lf;
  int          seq_err, zero_cnt, wrap_cnt, wrap_at, distinct;

  initial begin
    if16.en = 1'b1; if16.mode = 3'd1; if16.div = '0;
    if16.ain = 1'b0; if16.bin = 1'b0; if16.cin = 1'b0;
    if15.en = 1'b0; if15.mode = 3'd0; if15.div = '0;
    if15.ain = 1'b1; if15.bin = 1'b0; if15.cin = 1'b0;
    if4.en = 1'b1; if4.mode = 3'd1; if4.div = '0;
    if4.ain = 1'b0; if4.bin = 1'b0; if4.cin = 1'b0;

    // Reset held for three cycles
    repeat (3) cyc();
    check_vec("rst_allout", if16.allout, 64'h0);
    check_vec("rst_tick",   if16.tick,   64'h0);
    check_vec("rst_wrap",   if16.wrap,   64'h0);
    check_vec("rst_out",    if16.out,    64'h0);
    check_vec("rst_allout15", if15.allout, 64'h0);

    // Release: first cycle reseeds COUNT (mode_q resets to MIRROR), second cycle increments
    rst = 1'b0;
    cyc();
    check_vec("rel_allout", if16.allout, 64'h0);
    check_vec("rel_tick",   if16.tick,   64'h0);
    check_vec("mir15_a",     if15.allout, 64'h000F);
    check_vec("mir15_a_out", if15.out,    64'h0);
    if15.cin = 1'b1;
    cyc();
    check_vec("cnt_first",      if16.allout, 64'h1);
    check_vec("cnt_first_tick", if16.tick,   64'h1);
    check_vec("mir15_ac",       if15.allout, 64'h7F0F);
    check_vec("mir15_ac_out",   if15.out,    64'h1);
    check_vec("cnt4_first",     if4.allout,  64'h1);

    // WIDTH=4 COUNT wrap: 15 -> 0 on the 16th step only
    for (int k = 2; k <= 16; k++) begin
      cyc();
      check_vec("cnt4_val",  if4.allout, 64'(k % 16));
      check_vec("cnt4_wrap", if4.wrap,   (k == 16) ? 64'h1 : 64'h0);
    end

    // Unused mode encoding behaves as MIRROR
    if15.ain = 1'b0; if15.mode = 3'd6;
    cyc();
    check_vec("mir15_mode6",     if15.allout, 64'h7F00);
    check_vec("mir15_mode6_out", if15.out,    64'h1);

    // COUNT with div=3: one step every 4 cycles
    if16.mode = 3'd0;
    cyc();
    if16.mode = 3'd1; if16.div = 16'd3;
    cyc();
    check_vec("cnt_reseed", if16.allout, 64'h0);
    for (int s = 1; s <= 3; s++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        check_vec("div3_tick",   if16.tick,   (c == 4) ? 64'h1 : 64'h0);
        check_vec("div3_allout", if16.allout, (c == 4) ? 64'(s) : 64'(s - 1));
      end
    end

    // Lowering div below the running count ends the period at once
    if16.div = 16'd7;
    repeat (5) cyc();
    check_vec("div7_hold", if16.allout, 64'h3);
    check_vec("div7_tick", if16.tick,   64'h0);
    if16.div = 16'd2;
    cyc();
    check_vec("div_lower_allout", if16.allout, 64'h4);
    check_vec("div_lower_tick",   if16.tick,   64'h1);

    // Mode change on the terminal-count cycle wins over the step
    if16.div = 16'd3;
    repeat (3) cyc();
    if16.mode = 3'd4;
    cyc();
    check_vec("tog_seed",      if16.allout, 64'h5555);
    check_vec("tog_seed_tick", if16.tick,   64'h0);
    check_vec("tog_seed_wrap", if16.wrap,   64'h0);
    repeat (4) cyc();
    check_vec("tog_step1",      if16.allout, 64'hAAAA);
    check_vec("tog_step1_wrap", if16.wrap,   64'h0);
    repeat (4) cyc();
    check_vec("tog_step2",      if16.allout, 64'h5555);
    check_vec("tog_step2_wrap", if16.wrap,   64'h1);

    // WALK at div=0
    if16.mode = 3'd2; if16.div = '0;
    cyc();
    check_vec("walk_seed", if16.allout, 64'h1);
    for (int k = 1; k <= 19; k++) begin
      cyc();
      check_vec("walk_val",  if16.allout, 64'h1 << (k % 16));
      check_vec("walk_wrap", if16.wrap,   (k == 16) ? 64'h1 : 64'h0);
    end
    if16.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_vec("walk_frozen",      if16.allout, 64'h8);
      check_vec("walk_frozen_tick", if16.tick,   64'h0);
    end
    if16.en = 1'b1;
    cyc();
    check_vec("walk_resume",      if16.allout, 64'h10);
    check_vec("walk_resume_tick", if16.tick,   64'h1);

    // LFSR full period
    if16.mode = 3'd3;
    cyc();
    check_vec("lfsr_seed", if16.allout, 64'h1);
    lf = 16'h1; seq_err = 0; zero_cnt = 0; wrap_cnt = 0; wrap_at = 0; distinct = 0;
    for (int n = 1; n <= 65535; n++) begin
      cyc();
      lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0);
      if (n == 1) check_vec("lfsr_s1", if16.allout, 64'hB400);
      if (n == 2) check_vec("lfsr_s2", if16.allout, 64'h5A00);
      if (n == 3) check_vec("lfsr_s3", if16.allout, 64'h2D00);
      if (if16.allout !== lf) seq_err++;
      if (if16.allout == 16'h0) zero_cnt++;
      if (if16.wrap) begin
        wrap_cnt++;
        wrap_at = n;
      end
      if (!seen[if16.allout]) begin
        seen[if16.allout] = 1'b1;
        distinct++;
      end
    end
    check_vec("lfsr_seq_err",  64'(seq_err),  64'd0);
    check_vec("lfsr_zero",     64'(zero_cnt), 64'd0);
    check_vec("lfsr_wraps",    64'(wrap_cnt), 64'd1);
    check_vec("lfsr_wrap_at",  64'(wrap_at),  64'd65535);
    check_vec("lfsr_distinct", 64'(distinct), 64'd65535);
    check_vec("lfsr_end",      if16.allout,   64'h1);

    // Reset mid-pattern
    if16.cin = 1'b1;
    cyc();
    check_vec("pre_rst_out",    if16.out,    64'h1);
    check_vec("pre_rst_allout", if16.allout, 64'hB400);
    rst = 1'b1;
    cyc();
    check_vec("mid_rst_allout", if16.allout, 64'h0);
    check_vec("mid_rst_tick",   if16.tick,   64'h0);
    check_vec("mid_rst_wrap",   if16.wrap,   64'h0);
    check_vec("mid_rst_out",    if16.out,    64'h0);
    rst = 1'b0;
    cyc();
    check_vec("post_rst_allout", if16.allout, 64'h1);
    check_vec("post_rst_tick",   if16.tick,   64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
